// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Shared constants, types and helpers for the 4-digit scanned
//            seven-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  localparam int VALUE_W       = 14;
  localparam int NUM_POSITIONS = 4;
  localparam int BCD_W         = 4 * NUM_POSITIONS;

  localparam logic [3:0]         DIGIT_L   = 4'd10;
  localparam logic [3:0]         DIGIT_E   = 4'd11;
  localparam logic [VALUE_W-1:0] MAX_VALUE = 14'd9999;

  typedef logic [3:0] digit_t;

  typedef enum logic [0:0] {
    CONV_IDLE = 1'b0,
    CONV_RUN  = 1'b1
  } conv_state_t;

  // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift
  function automatic digit_t add3_adjust(input digit_t d);
    return (d >= 4'd5) ? digit_t'(d + 4'd3) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd
// Brief    : Sequential shift-add-3 binary to BCD converter, one input bit
//            per clock, MSB first. o_done/o_bcd present the final result
//            combinationally during the last iteration cycle so the caller
//            can capture it on the same edge that ends the conversion.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd
  import seven_seg_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam logic [3:0] LAST_STEP = 4'(VALUE_W - 1);

  conv_state_t        r_state;
  conv_state_t        w_state_nxt;
  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [3:0]         r_cnt;
  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_last;

  assign w_last = (r_cnt == LAST_STEP);
  assign o_busy = (r_state == CONV_RUN);
  assign o_bcd  = w_bcd_nxt;

  // One double-dabble iteration: adjust every nibble, then shift in the next bit
  always_comb begin
    w_adj = '0;
    for (int k = 0; k < NUM_POSITIONS; k++) begin
      w_adj[4*k +: 4] = add3_adjust(r_bcd[4*k +: 4]);
    end
    w_bcd_nxt = {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
  end

  // Next-state and done strobe
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      CONV_IDLE: begin
        if (i_start) begin
          w_state_nxt = CONV_RUN;
        end
      end
      CONV_RUN: begin
        if (w_last) begin
          w_state_nxt = CONV_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = CONV_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= CONV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift datapath: capture on start, then one iteration per cycle while running
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if ((r_state == CONV_IDLE) && i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV_RUN) begin
      r_bin <= {r_bin[VALUE_W-2:0], 1'b0};
      r_bcd <= w_bcd_nxt;
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Captures a 14-bit binary value, converts it to four BCD digits
//            in the background and time-multiplexes the stored digits over
//            four display positions. Values above 9999 display E,E,E,E.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [VALUE_W-1:0] value,
  output logic               busy,
  output logic               error,
  output logic [3:0]         digit,
  output logic [1:0]         position
);

  localparam int               PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_pos;
  digit_t           r_digits [NUM_POSITIONS];
  logic             r_error;
  logic             w_accept;
  logic             w_conv_busy;
  logic             w_conv_done;
  logic [BCD_W-1:0] w_bcd;

  // A load is only taken while the converter is idle; requests during busy are dropped
  assign w_accept = load & ~w_conv_busy;

  bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_bin   (value),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  assign busy     = w_conv_busy;
  assign error    = r_error;
  assign position = r_pos;
  assign digit    = r_digits[r_pos];

  // Free-running refresh prescaler advancing the display position on wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_pos <= 2'd0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      r_pos <= r_pos + 2'd1;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Range flag is decided at capture time and held until the next accepted load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= (value > MAX_VALUE);
    end
  end

  // Displayed digits change all at once when the conversion finishes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_POSITIONS; k++) begin
        r_digits[k] <= '0;
      end
    end else if (w_conv_done) begin
      for (int k = 0; k < NUM_POSITIONS; k++) begin
        r_digits[k] <= r_error ? DIGIT_E : w_bcd[4*k +: 4];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles each digit position is held (legal range 2..2^20).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port load  input  1  request to capture value; accepted only when busy=0.
REQ-005 The block SHALL have port value  input  14  unsigned binary number to display, 0..16383.
REQ-006 The block SHALL have port busy  output  1  conversion in progress; load ignored while high.
REQ-007 The block SHALL have port error  output  1  last accepted value exceeded 9999.
REQ-008 The block SHALL have port digit  output  4  digit code for current position (0-9 decimal, 10=L, 11=E), feeds the downstream segment decoder.
REQ-009 The block SHALL have port position  output  2  active display position 0..3 (0 = least significant digit).

Function
REQ-010 Acceptance: load=1 with busy=0 in cycle N SHALL capture value; busy SHALL be 1 in cycles N+1..N+14 inclusive and 0 in N+15.
REQ-011 Conversion SHALL be sequential shift-add-3 (double dabble), one value bit per cycle, MSB first, 14 iterations, producing four BCD digits.
REQ-012 The displayed digit register set SHALL update atomically on the edge ending cycle N+14; partial BCD results SHALL never appear on digit.
REQ-013 During conversion the previous digit set SHALL continue to be displayed unchanged.
REQ-014 If captured value > 9999, error SHALL be 1 from cycle N+1, and at completion all four stored digits SHALL be 11 (E); otherwise error SHALL be 0 from cycle N+1.
REQ-015 load asserted while busy=1 SHALL be ignored with no effect on state; no queuing.
REQ-016 load held high continuously SHALL be accepted again in the first cycle busy=0 (back-to-back every 15 cycles).
REQ-017 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on the wrap cycle position SHALL increment modulo 4 (3 -> 0).
REQ-018 Scanning SHALL run continuously, independent of load/busy.
REQ-019 digit SHALL equal stored digit[position] combinationally from registered state; digit and position change on the same edge.
REQ-020 No leading-zero blanking: value 7 displays 0,0,0,7.

Reset
REQ-021 rst_n=0 sampled on a clock edge SHALL set: position=0, prescaler=0, all stored digits=0, digit=0, busy=0, error=0, abort any conversion.
REQ-022 Reset mid-conversion SHALL discard the partial result; stored digits become 0.
REQ-023 load asserted in the same cycle as rst_n=0 SHALL be ignored.
REQ-024 First accepted load is possible in the first cycle with rst_n=1.

Structure
REQ-025 Shared package seven_seg_pkg SHALL hold DIGIT_L=10, DIGIT_E=11, MAX_VALUE=9999, NUM_POSITIONS=4, VALUE_W=14.
REQ-026 The converter SHALL be a sub-module bin2bcd (start/busy/done, 14-bit in, 16-bit BCD out); scan logic and digit storage remain in seven_seg_scan.
REQ-027 Expected size 150-300 lines RTL total; no vendor primitives.

Verification (REFRESH_DIV=4 in bench)
REQ-028 Reset, no load -> position cycles 0,1,2,3,0 every 4 cycles, digit=0 throughout, busy=0, error=0.
REQ-029 load value=1234 -> busy high exactly 14 cycles; then position 0..3 yields digit 4,3,2,1; error=0.
REQ-030 load 9999 then load 10000 -> first shows 9,9,9,9 error=0; second error=1 next cycle and shows 11,11,11,11.
REQ-031 load 42 then load 7 asserted at cycle 5 of busy -> second ignored; display 2,4,0,0.
REQ-032 load 5678, rst_n=0 at busy cycle 8 -> busy=0, error=0, digits 0,0,0,0, position=0 next cycle.
REQ-033 load held high with value 0 then 16383 switched mid-busy -> accepts at 15-cycle intervals; second accepted value shows E,E,E,E error=1.
